ecc_encoder_stream: RTL and testbench
=====================================

// Module: ecc_encoder_stream
// PURPOSE
//  Streaming Hamming(15,11) encoder for PUF helper-data enrollment. It is the transmit-side counterpart of
//  the ECC decoder: codeword bit order and parity positions match the decoder exactly, so decode(encode(d))==d.
//  Accepts 11-bit words over valid/ready, emits registered 15-bit codewords and marks frame boundaries.
//  Optional single-bit error injection supports ECC path verification.
// PARAMETERS
//  WORDS_PER_FRAME  4  codewords per helper-data frame (>=1); out_last marks the final word of each frame
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  enable       in   1     0: in_ready forced low, pipeline and counter hold their state
//  clear        in   1     synchronous flush: drops held word, frame counter->0 (wins over all else)
//  in_valid     in   1     input word valid
//  in_ready     out  1     encoder accepts the word this cycle
//  in_data      in   [0:10] message bits d0..d10
//  err_inj_pos  in   [3:0] 0=no injection; 1..15 flips codeword bit (pos-1), sampled with the word
//  out_valid    out  1     codeword valid
//  out_ready    in   1     downstream accepts
//  out_code     out  [0:14] codeword c0..c14 (c0 is MSB of a packed literal)
//  out_last     out  1     codeword is the last word of its frame
//  frame_done   out  1     1-cycle pulse on the cycle the last word of a frame is accepted downstream
// BEHAVIOUR
//  Reset: out_valid=0, out_code=0, out_last=0, frame_done=0, frame counter=0.
//  Mapping: c2=d0 c4=d1 c5=d2 c6=d3 c8=d4 c9=d5 c10=d6 c11=d7 c12=d8 c13=d9 c14=d10.
//  Parity (XOR): c0=^{c2,c4,c6,c8,c10,c12,c14}; c1=^{c2,c5,c6,c9,c10,c13,c14};
//   c3=^{c4,c5,c6,c11,c12,c13,c14}; c7=^{c8..c14}. Parity is computed before error injection.
//  Handshake: in_ready = enable & (!out_valid | out_ready). Accept = in_valid & in_ready.
//   Latency 1 cycle: word accepted in cycle N appears on out_code in N+1; full throughput 1 word/cycle.
//   out_code/out_last are stable while out_valid & !out_ready; out_valid drops only after acceptance
//   with no new accept in the same cycle. Simultaneous out accept + in accept replaces the register.
//  Frame counter: increments per accepted input word; word with counter==WORDS_PER_FRAME-1 is tagged
//   out_last=1 and the counter wraps to 0. frame_done=out_valid&out_ready&out_last, registered? no:
//   frame_done is registered, asserted the cycle after that handshake, for exactly one cycle.
//  enable=0 mid-stream: no new accepts; an already-held codeword remains valid and may still drain.
//  clear=1: out_valid->0, counter->0, frame_done->0 next edge; input ignored that cycle.
//  Async rst mid-operation: all state returns to reset values immediately; held word is lost.
//  err_inj_pos 1..15: exactly one bit flipped; values are 4-bit so no out-of-range case exists.
// STRUCTURE
//  ecc_pkg: K=11, N=15, parity-position constants {0,1,3,7}, data-position table, and function
//   hamming15_11_parity(); to be shared with the decoder.
//  Sub-module hamming15_11_enc_core: combinational data->codeword; top adds register, handshake and counter.
// TESTING
//  1 in_data=11'h000 -> out_code=15'h0000 one cycle later; 11'h7FF -> 15'h7FFF.
//  2 d0 only (in_data=11'b100_0000_0000) -> 15'h7000; d10 only (11'h001) -> 15'h6881.
//  3 Back-pressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_code held, no word lost
//    or duplicated; 8 random words streamed with random stalls match golden model in order.
//  4 WORDS_PER_FRAME=4, 8 words -> out_last on words 4 and 8, frame_done pulses twice, one cycle after
//    each last-word handshake.
//  5 err_inj_pos=3 with data 11'h000 -> out_code=15'h1000; feeding every injected codeword (pos 1..15)
//    into the ECC decoder returns the original data.
//  6 clear and async rst asserted while out_valid=1 and counter=2 -> out_valid=0, next frame's 4th word
//    carries out_last; enable=0 -> in_ready=0 while held word still drains.

Source files
------------

// File: rtl/ecc_pkg.sv
// Hamming(15,11) definitions shared by the helper-data encoder and decoder:
// code geometry, bit-position tables and the parity function.
package ecc_pkg;

   localparam int K = 11;   // message bits
   localparam int N = 15;   // codeword bits
   localparam int P = 4;    // parity bits

   typedef logic [0:K-1] data_t;   // d0..d10, d0 is the MSB of a packed literal
   typedef logic [0:N-1] code_t;   // c0..c14, c0 is the MSB of a packed literal

   // Parity bit j sits at codeword index 2**j - 1 (1-based position 2**j).
   localparam int PARITY_POS [P] = '{0, 1, 3, 7};

   // Codeword index receiving message bit d<i>.
   localparam int DATA_POS [K] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

   // Parity bit j covers every codeword index whose 1-based position has bit j set.
   // The parity position itself is skipped, so the input may hold any value there.
   function automatic logic [0:P-1] hamming15_11_parity(input code_t c);
      logic [0:P-1] p;
      p = '0;
      for (int j = 0; j < P; j++) begin
         for (int i = 0; i < N; i++) begin
            if ((((i + 1) >> j) & 1) == 1 && i != PARITY_POS[j]) begin
               p[j] = p[j] ^ c[i];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/ecc_encoder_stream_if.sv
// Valid/ready stream bundle of the encoder: 11-bit message words (with an
// error-injection tag) in, 15-bit codewords with a frame marker out.
interface ecc_encoder_stream_if;
   import ecc_pkg::*;

   logic       in_valid;
   logic       in_ready;
   data_t      in_data;
   logic [3:0] err_inj_pos;

   logic       out_valid;
   logic       out_ready;
   code_t      out_code;
   logic       out_last;

   // Encoder side
   modport slave (
      input  in_valid, in_data, err_inj_pos, out_ready,
      output in_ready, out_valid, out_code, out_last
   );

   // Producer/consumer side
   modport master (
      output in_valid, in_data, err_inj_pos, out_ready,
      input  in_ready, out_valid, out_code, out_last
   );

endinterface

// File: rtl/hamming15_11_enc_core.sv
// Combinational Hamming(15,11) encoder: scatters the message into its data
// positions and fills the four parity positions.
module hamming15_11_enc_core
   import ecc_pkg::*;
(
   input  data_t data,
   output code_t code
);

   code_t        placed;   // message in place, parity slots zero
   logic [0:P-1] parity;

   for (genvar gi = 0; gi < K; gi++) begin : g_data
      assign placed[DATA_POS[gi]] = data[gi];
      assign code[DATA_POS[gi]]   = data[gi];
   end

   for (genvar gi = 0; gi < P; gi++) begin : g_parity
      assign placed[PARITY_POS[gi]] = 1'b0;
      assign code[PARITY_POS[gi]]   = parity[gi];
   end

   assign parity = hamming15_11_parity(placed);

endmodule

// File: rtl/ecc_encoder_stream.sv
// Streaming Hamming(15,11) encoder: one output register stage with valid/ready
// handshake, optional single-bit error injection and frame tagging.
module ecc_encoder_stream
   import ecc_pkg::*;
#(
   parameter int WORDS_PER_FRAME = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                clear,
   ecc_encoder_stream_if.slave bus,
   output logic                frame_done
);

   localparam int            CW       = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WORDS_PER_FRAME - 1);

   code_t         enc_code;
   code_t         flip_mask;
   code_t         code_reg, code_next;
   logic          valid_reg, valid_next;
   logic          last_reg, last_next;
   logic          done_reg, done_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          in_ready;
   logic          in_accept;
   logic          out_accept;

   hamming15_11_enc_core u_core (
      .data (bus.in_data),
      .code (enc_code)
   );

   // One-hot flip mask: err_inj_pos=n flips codeword index n-1, 0 flips nothing.
   for (genvar gi = 0; gi < N; gi++) begin : g_flip
      assign flip_mask[gi] = (bus.err_inj_pos == 4'(gi + 1));
   end

   // Handshake decode and next-state of the output register and frame counter.
   // The register is free when empty or being drained, so a drain and a new
   // accept in the same cycle simply replace its contents.
   always_comb begin
      in_ready   = enable & ~clear & (~valid_reg | bus.out_ready);
      in_accept  = bus.in_valid & in_ready;
      out_accept = valid_reg & bus.out_ready;
      code_next  = code_reg;
      valid_next = valid_reg;
      last_next  = last_reg;
      cnt_next   = cnt_reg;
      done_next  = out_accept & last_reg;
      if (clear) begin
         valid_next = 1'b0;
         cnt_next   = '0;
         done_next  = 1'b0;
      end else if (in_accept) begin
         valid_next = 1'b1;
         code_next  = enc_code ^ flip_mask;   // parity computed before the flip
         last_next  = (cnt_reg == LAST_CNT);
         cnt_next   = (cnt_reg == LAST_CNT) ? '0 : cnt_reg + 1'b1;
      end else if (out_accept) begin
         valid_next = 1'b0;
      end
   end

   // State registers; asynchronous reset discards any held codeword.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_reg  <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
         done_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         code_reg  <= code_next;
         valid_reg <= valid_next;
         last_reg  <= last_next;
         done_reg  <= done_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_reg;
   assign bus.out_code  = code_reg;
   assign bus.out_last  = last_reg;
   assign frame_done    = done_reg;

endmodule

// File: tb/tb_ecc_encoder_stream.sv
// Self-checking bench for ecc_encoder_stream: fixed vector table, directed
// corner sequences and randomized streaming against a behavioural model.
module tb_ecc_encoder_stream;
   import ecc_pkg::*;

   localparam int WPF = 4;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic clear;
   logic frame_done;

   always #5 clk = ~clk;

   ecc_encoder_stream_if bus ();

   ecc_encoder_stream #(.WORDS_PER_FRAME(WPF)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clear      (clear),
      .bus        (bus),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [0:10] data;
      logic [3:0]  pos;
      logic [0:14] code;
   } vec_t;

   typedef struct {
      logic [0:14] code;
      logic        last;
   } exp_t;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t exp_q[$];
   int   mdl_cnt     = 0;
   logic fd_exp      = 1'b0;
   bit   mon_on      = 1'b0;
   int   fd_count    = 0;
   int   out_idx     = 0;
   logic [31:0] last_log = '0;

   // Reference encoder written straight from the bit mapping and parity equations.
   function automatic logic [0:14] ref_encode(input logic [0:10] d, input logic [3:0] pos);
      logic [0:14] c;
      c = '0;
      c[2]  = d[0];  c[4]  = d[1];  c[5]  = d[2];  c[6]  = d[3];
      c[8]  = d[4];  c[9]  = d[5];  c[10] = d[6];  c[11] = d[7];
      c[12] = d[8];  c[13] = d[9];  c[14] = d[10];
      c[0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
      c[1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
      c[3] = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
      c[7] = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
      if (pos != 4'd0) c[int'(pos) - 1] = ~c[int'(pos) - 1];
      return c;
   endfunction

   // Reference decoder: syndrome is the XOR of 1-based positions of set bits.
   function automatic logic [0:10] ref_decode(input logic [0:14] cw);
      logic [0:14] c;
      int syn;
      c   = cw;
      syn = 0;
      for (int i = 0; i < 15; i++) if (c[i]) syn = syn ^ (i + 1);
      if (syn != 0) c[syn - 1] = ~c[syn - 1];
      return {c[2], c[4], c[5], c[6], c[8], c[9], c[10], c[11], c[12], c[13], c[14]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle model step, evaluated on the falling edge before the handshake edge.
   task automatic mon_step();
      logic exp_ir;
      exp_t e;
      exp_ir = enable & ~clear & ((exp_q.size() == 0) | bus.out_ready);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (frame_done) fd_count++;
      if (exp_q.size() != 0) begin
         chk("out_code", 32'(bus.out_code), 32'(exp_q[0].code));
         chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
      end
      if (clear) begin
         exp_q.delete();
         mdl_cnt = 0;
         fd_exp  = 1'b0;
      end else begin
         fd_exp = 1'b0;
         if (exp_q.size() != 0 && bus.out_ready) begin
            fd_exp = exp_q[0].last;
            if (bus.out_last && out_idx < 32) last_log[out_idx] = 1'b1;
            out_idx++;
            void'(exp_q.pop_front());
         end
         if (bus.in_valid && exp_ir) begin
            e.code = ref_encode(bus.in_data, bus.err_inj_pos);
            e.last = (mdl_cnt == WPF - 1);
            exp_q.push_back(e);
            mdl_cnt = (mdl_cnt == WPF - 1) ? 0 : mdl_cnt + 1;
         end
      end
   endtask

   task automatic tick(output bit acc);
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      if (mon_on) mon_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) tick(a);
   endtask

   // Present one word and hold it until accepted (bounded).
   task automatic send(input logic [0:10] d, input logic [3:0] p);
      bit acc;
      int n;
      n = 0;
      bus.in_valid    = 1'b1;
      bus.in_data     = d;
      bus.err_inj_pos = p;
      do begin
         tick(acc);
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("send_timeout", 32'(acc), 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic do_clear();
      bus.in_valid = 1'b0;
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
   endtask

   task automatic reset_log();
      last_log = '0;
      out_idx  = 0;
      fd_count = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [5];
      logic [0:10] d, w0, w1;
      int          sent, cyc;
      bit          acc;

      tbl[0] = '{data: 11'h000, pos: 4'd0, code: 15'h0000};
      tbl[1] = '{data: 11'h7FF, pos: 4'd0, code: 15'h7FFF};
      tbl[2] = '{data: 11'h400, pos: 4'd0, code: 15'h7000};
      tbl[3] = '{data: 11'h001, pos: 4'd0, code: 15'h6881};
      tbl[4] = '{data: 11'h000, pos: 4'd3, code: 15'h1000};

      rst             = 1'b1;
      enable          = 1'b0;
      clear           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.err_inj_pos = '0;
      bus.out_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_code", 32'(bus.out_code), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      rst    = 1'b0;
      enable = 1'b1;
      mon_on = 1'b1;

      // Fixed vectors: codeword one cycle after acceptance.
      for (int i = 0; i < 5; i++) begin
         send(tbl[i].data, tbl[i].pos);
         chk("tbl_out_valid", 32'(bus.out_valid), 32'd1);
         chk("tbl_out_code", 32'(bus.out_code), 32'(tbl[i].code));
      end
      idle(2);

      // Frame tagging: 8 words at full rate, last on words 4 and 8.
      do_clear();
      reset_log();
      for (int i = 0; i < 8; i++) send(11'($urandom), 4'd0);
      idle(3);
      chk("frame_last_pattern", last_log, 32'h88);
      chk("frame_done_pulses", 32'(fd_count), 32'd2);

      // Back-pressure: held word stable, no accepts, then in-order release.
      bus.out_ready = 1'b0;
      w0 = 11'($urandom);
      w1 = 11'($urandom);
      send(w0, 4'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = w1;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_out_code", 32'(bus.out_code), 32'(ref_encode(w0, 4'd0)));
      end
      bus.out_ready = 1'b1;
      send(w1, 4'd0);
      idle(2);

      // Error injection at every position decodes back to the message.
      for (int p = 1; p <= 15; p++) begin
         d = 11'($urandom);
         send(d, 4'(p));
         chk("inj_decode", 32'(ref_decode(bus.out_code)), 32'(d));
      end
      idle(2);

      // Randomized stream with random stalls.
      sent = 0;
      cyc  = 0;
      while (sent < 40 && cyc < 2000) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
            bus.in_valid    = 1'b1;
            bus.in_data     = 11'($urandom);
            bus.err_inj_pos = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         end
         tick(acc);
         cyc++;
         if (acc) begin
            sent++;
            bus.in_valid = 1'b0;
         end
      end
      chk("random_stream_done", 32'(sent), 32'd40);
      bus.in_valid    = 1'b0;
      bus.err_inj_pos = 4'd0;
      bus.out_ready   = 1'b1;
      idle(3);

      // clear with a held word and counter at 2; next frame ends on its 4th word.
      do_clear();
      send(11'($urandom), 4'd0);
      send(11'($urandom), 4'd0);
      bus.out_ready = 1'b0;
      idle(1);
      chk("pre_clear_valid", 32'(bus.out_valid), 32'd1);
      do_clear();
      chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      reset_log();
      for (int i = 0; i < 4; i++) send(11'($urandom), 4'd0);
      idle(2);
      chk("clear_frame_last", last_log, 32'h8);

      // Async reset under the same conditions.
      send(11'($urandom), 4'd0);
      send(11'($urandom), 4'd0);
      bus.out_ready = 1'b0;
      idle(1);
      #2 rst = 1'b1;
      mon_on = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out_code", 32'(bus.out_code), 32'd0);
      chk("arst_out_last", 32'(bus.out_last), 32'd0);
      chk("arst_frame_done", 32'(frame_done), 32'd0);
      exp_q.delete();
      mdl_cnt = 0;
      fd_exp  = 1'b0;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_on = 1'b1;
      bus.out_ready = 1'b1;
      reset_log();
      for (int i = 0; i < 4; i++) send(11'($urandom), 4'd0);
      idle(2);
      chk("arst_frame_last", last_log, 32'h8);

      // enable=0: held word drains, nothing new accepted.
      bus.out_ready = 1'b0;
      send(11'($urandom), 4'd0);
      enable       = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 11'($urandom);
      #1;
      chk("dis_in_ready", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      idle(1);
      chk("dis_drained", 32'(bus.out_valid), 32'd0);
      idle(2);
      chk("dis_no_accept", 32'(bus.out_valid), 32'd0);
      enable = 1'b1;
      idle(1);
      bus.in_valid = 1'b0;
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
